wave_display_mc: RTL and testbench
==================================

# wave_display_mc

Multi-channel oscilloscope trace renderer for the VGA pipeline; parametrised successor of the single-channel wave display. For each pixel it draws up to CHANNELS waveforms, each in its own colour, from one shared sample RAM port. Samples are prefetched one column ahead by a small sequencer. The RGB output is registered. The block sits between the sample RAM (double-buffered via `read_index`) and the VGA timing/output stage.

## Interface
- CHANNELS, 4: number of traces; CH_W = max(1, clog2(CHANNELS)).
- SAMPLE_W, 8: RAM sample width.
- COL_SHIFT, 3: column width COL_W = 2^COL_SHIFT pixels; constraint CHANNELS+1 ≤ COL_W.
- COL_BITS, 7: NUM_COLS = 2^COL_BITS columns per line.
- X_START, 256: first drawn x; constraint X_START ≥ COL_W.
- Y_SHIFT, 1: y_val = y >> Y_SHIFT; Y_W = 10 − Y_SHIFT.
- SCALE_SHIFT, 1 and Y_OFFSET, 32: plot value = (sample >> SCALE_SHIFT) + Y_OFFSET.
- CH_COLORS, {24'hFFFF00, 24'h00FFFF, 24'hFF00FF, 24'hFFFFFF}: packed 24-bit RGB per channel; channel 0 is the LSBs.
- clk  in  1  pixel clock.
- reset  in  1  asynchronous, active-high; clears all state.
- x  in  11  pixel column; +1 per clk while valid.
- y  in  10  pixel row.
- valid  in  1  x/y are in the active area.
- read_index  in  1  RAM buffer select.
- ch_enable  in  CHANNELS  per-channel display mask.
- dot_mode  in  1  0 = connected line, 1 = sample points only.
- read_address  out  1+CH_W+COL_BITS  {index, channel, column}.
- read_value  in  SAMPLE_W  RAM data, one clk after read_address.
- valid_pixel  out  1  registered; high inside the trace window.
- r, g, b  out  8 each  registered pixel colour.

## Operation
- Column col = (x − X_START) >> COL_SHIFT. Window = X_START ≤ x < X_START + NUM_COLS·COL_W. Column boundary = window x with low COL_SHIFT bits of (x − X_START) equal to 0.
- Pre-roll at x == X_START − COL_W with valid: latch read_index into line_index (held for the whole line; mid-line changes are ignored); fetch column 0.
- Sequencer states:
  - IDLE: idle state.
  - FETCH: issue channel k = 0..CHANNELS−1, one per clk, read_address = {line_index, k, fcol}.
  - DRAIN: capture the last channel, then return to IDLE.
  - Each read_value is captured into nxt[k−1] the cycle after its issue.
  - In IDLE, read_address holds its last value.
- At each column boundary:
  - prev ← cur, cur ← nxt, per-channel validity flags shift the same way.
  - If col+1 < NUM_COLS, start a FETCH of fcol = col+1.
  - At the col-0 boundary, prev is marked invalid.
- Plot value is computed in Y_W+1 bits and saturates to 2^Y_W − 1.
- Channel k hits when ch_enable[k], cur valid, and:
  - line mode: y_val lies between prev and cur inclusive, in either order; if prev is invalid, y_val == cur.
  - dot mode: y_val == cur.
- Lowest-index hitting channel wins and outputs its CH_COLORS entry; otherwise black.
- valid low at any time: sequencer → IDLE, all validity flags cleared, nothing drawn until the next pre-roll.

## Timing
- Output latency 1 clk: r/g/b/valid_pixel at cycle t+1 reflect x/y/valid at t.
- Reset values: r = g = b = 0, valid_pixel = 0, read_address = 0, state IDLE, all sample registers and flags 0, line_index = 0.
- A fetch completes CHANNELS+1 clks after the boundary, always before the next boundary.
- Reset asserted mid-fetch clears immediately. The first draw after release needs a fresh pre-roll.

## Test plan
- Reset: assert reset mid-line → all outputs 0 asynchronously; after release with no pre-roll, pixels stay black.
- Fetch order (defaults, read_index = 1, x ramping from 240):
  - at x = 248..251, read_address = 0x200, 0x280, 0x300, 0x380;
  - at x = 256..259, read_address = 0x201, 0x281, 0x301, 0x381;
  - flip read_index at x = 300 → addresses keep MSB = 1.
- Line mode: ch0 samples col0 = 64, col1 = 128 (plots 64, 96):
  - col 0: only y_val = 64 is yellow (FFFF00);
  - col 1: y_val 64..96 is yellow, y_val 97 is black;
  - all with a 1-clk lag.
- Priority/mask: ch0 and ch1 given identical samples → FFFF00; ch_enable = 4'b1110 → 00FFFF; ch_enable = 0 → black everywhere.
- Dot mode: same data as the line-mode test → col 1 lights only y_val = 96; y_val = 80 is black.
- Valid drop: deassert valid at x = 400 for 3 clks, then resume → sequencer IDLE, black until the next line's pre-roll; normal trace on the following line.

Source files
------------

// File: rtl/wave_display_mc_if.sv
// Pixel-stream, sample-RAM and colour-output signals of the multi-channel
// wave display, bundled so the renderer and its surroundings connect in one go.
interface wave_display_mc_if #(
  parameter int CHANNELS = 4,
  parameter int SAMPLE_W = 8,
  parameter int COL_BITS = 7
);
  localparam int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int ADDR_W = 1 + CH_W + COL_BITS;

  // Pixel timing side
  logic [10:0]          x;
  logic [9:0]           y;
  logic                 valid;
  // Display controls
  logic                 read_index;
  logic [CHANNELS-1:0]  ch_enable;
  logic                 dot_mode;
  // Sample RAM port: {index, channel, column}, data one clk after address
  logic [ADDR_W-1:0]    read_address;
  logic [SAMPLE_W-1:0]  read_value;
  // Registered pixel output
  logic                 valid_pixel;
  logic [7:0]           r;
  logic [7:0]           g;
  logic [7:0]           b;

  // Drives pixels/controls and serves the RAM; observes colour output.
  modport master (
    output x, y, valid, read_index, ch_enable, dot_mode, read_value,
    input  read_address, valid_pixel, r, g, b
  );

  // The renderer itself.
  modport slave (
    input  x, y, valid, read_index, ch_enable, dot_mode, read_value,
    output read_address, valid_pixel, r, g, b
  );
endinterface

// File: rtl/wave_display_mc.sv
// Multi-channel oscilloscope trace renderer. A small sequencer prefetches one
// sample per channel for the next column from a shared RAM port; at each
// column boundary the next/current/previous sample sets shift, and every pixel
// is tested against all enabled traces. Lowest channel index wins; the RGB
// output is registered (one clk latency).
module wave_display_mc #(
  parameter int CHANNELS    = 4,
  parameter int SAMPLE_W    = 8,
  parameter int COL_SHIFT   = 3,
  parameter int COL_BITS    = 7,
  parameter int X_START     = 256,
  parameter int Y_SHIFT     = 1,
  parameter int SCALE_SHIFT = 1,
  parameter int Y_OFFSET    = 32,
  // Channel 0 occupies the least significant 24 bits.
  parameter logic [24*CHANNELS-1:0] CH_COLORS =
    {24'hFFFFFF, 24'hFF00FF, 24'h00FFFF, 24'hFFFF00}
) (
  input  logic              clk,
  input  logic              reset,
  wave_display_mc_if.slave  bus
);

  localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int ADDR_W   = 1 + CH_W + COL_BITS;
  localparam int COL_W    = 1 << COL_SHIFT;
  localparam int NUM_COLS = 1 << COL_BITS;
  localparam int Y_W      = 10 - Y_SHIFT;
  localparam int X_END    = X_START + NUM_COLS * COL_W;
  localparam int X_PRE    = X_START - COL_W;

  localparam logic [CH_W-1:0]     K_LAST   = CH_W'(CHANNELS - 1);
  localparam logic [COL_BITS-1:0] COL_LAST = COL_BITS'(NUM_COLS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN
  } state_t;

  typedef logic [CHANNELS-1:0][SAMPLE_W-1:0] sample_set_t;

  // ---------------------------------------------------------------------------
  // Pixel position decode
  // ---------------------------------------------------------------------------
  logic [10:0]         dx;
  logic [COL_BITS-1:0] col;
  logic [Y_W-1:0]      y_val;
  logic                in_window;
  logic                at_boundary;
  logic                is_preroll;
  logic                first_col;
  logic                has_next;

  assign dx          = bus.x - 11'(X_START);
  assign col         = COL_BITS'(dx >> COL_SHIFT);
  assign y_val       = Y_W'(bus.y >> Y_SHIFT);
  assign in_window   = (int'(bus.x) >= X_START) && (int'(bus.x) < X_END);
  assign at_boundary = in_window && (dx[COL_SHIFT-1:0] == '0);
  assign is_preroll  = (int'(bus.x) == X_PRE);
  assign first_col   = (col == '0);
  assign has_next    = (col != COL_LAST);

  // ---------------------------------------------------------------------------
  // Sequencer state
  // ---------------------------------------------------------------------------
  state_t              state_q, state_d;
  logic [CH_W-1:0]     k_q, k_d;
  logic [COL_BITS-1:0] fcol_q, fcol_d;
  logic                line_index_q, line_index_d;
  logic                line_active_q, line_active_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W-1:0]   addr_d;

  logic                start;
  logic                shift;
  logic                idx_start;
  logic [COL_BITS-1:0] fcol_start;
  logic                cap_en;
  logic [CH_W-1:0]     cap_ch;

  // A fetch starts at the pre-roll pixel, or at any boundary of an active line
  // that still has a column after it. Boundaries only count once pre-rolled.
  assign start      = bus.valid &&
                      (is_preroll || (line_active_q && at_boundary && has_next));
  assign shift      = bus.valid && line_active_q && at_boundary;
  assign idx_start  = is_preroll ? bus.read_index : line_index_q;
  assign fcol_start = is_preroll ? '0 : col + COL_BITS'(1);

  // Sequencer next-state: channel 0 goes out in the start cycle itself, the
  // rest one per clk in FETCH; each sample is captured one clk after issue.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    state_d       = state_q;
    k_d           = k_q;
    fcol_d        = fcol_q;
    line_index_d  = line_index_q;
    line_active_d = line_active_q;
    addr_d        = addr_q;
    cap_en        = 1'b0;
    cap_ch        = '0;

    case (state_q)
      S_FETCH: begin
        addr_d = {line_index_q, k_q, fcol_q};
        cap_en = 1'b1;
        cap_ch = k_q - CH_W'(1);
        if (k_q == K_LAST) begin
          state_d = S_DRAIN;
        end else begin
          k_d = k_q + CH_W'(1);
        end
      end
      S_DRAIN: begin
        cap_en  = 1'b1;
        cap_ch  = K_LAST;
        state_d = S_IDLE;
      end
      default: ;
    endcase

    if (start) begin
      addr_d  = {idx_start, CH_W'(0), fcol_start};
      fcol_d  = fcol_start;
      k_d     = CH_W'(1);
      state_d = (CHANNELS > 1) ? S_FETCH : S_DRAIN;
    end

    // The buffer select is sampled once per line; later flips are ignored.
    if (bus.valid && is_preroll) begin
      line_index_d  = bus.read_index;
      line_active_d = 1'b1;
    end

    // Leaving the active area abandons the line until the next pre-roll.
    if (!bus.valid) begin
      state_d       = S_IDLE;
      k_d           = '0;
      line_active_d = 1'b0;
      cap_en        = 1'b0;
    end
  end

  assign bus.read_address = addr_d;

  // Sequencer registers; addr_q keeps the last issued address while idle.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (reset) begin
      state_q       <= S_IDLE;
      k_q           <= '0;
      fcol_q        <= '0;
      line_index_q  <= 1'b0;
      line_active_q <= 1'b0;
      addr_q        <= '0;
    end else begin
      state_q       <= state_d;
      k_q           <= k_d;
      fcol_q        <= fcol_d;
      line_index_q  <= line_index_d;
      line_active_q <= line_active_d;
      addr_q        <= addr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Sample pipeline: next (being fetched), current and previous column
  // ---------------------------------------------------------------------------
  sample_set_t         nxt_q, cur_q, prev_q;
  logic [CHANNELS-1:0] nxt_vld_q, cur_vld_q, prev_vld_q;

  // Capture fetched samples and shift the column sets at each boundary.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: these sample sets are a handful of flops, not RAM, so they take the async reset like other state.
    if (reset) begin
      nxt_q      <= '0;
      cur_q      <= '0;
      prev_q     <= '0;
      nxt_vld_q  <= '0;
      cur_vld_q  <= '0;
      prev_vld_q <= '0;
    end else if (!bus.valid) begin
      nxt_vld_q  <= '0;
      cur_vld_q  <= '0;
      prev_vld_q <= '0;
    end else begin
      if (shift) begin
        prev_q     <= cur_q;
        cur_q      <= nxt_q;
        cur_vld_q  <= nxt_vld_q;
        prev_vld_q <= first_col ? '0 : cur_vld_q;
      end
      if (start) begin
        nxt_vld_q <= '0;
      end
      if (cap_en) begin
        nxt_q[cap_ch]     <= bus.read_value;
        nxt_vld_q[cap_ch] <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Hit test
  // ---------------------------------------------------------------------------
  // Scale and offset a sample into a plot row, saturating at the top row.
  function automatic logic [Y_W-1:0] plot_of(input logic [SAMPLE_W-1:0] s);
    logic [Y_W:0] sum;
    sum = (Y_W+1)'(s >> SCALE_SHIFT) + (Y_W+1)'(Y_OFFSET);
    return sum[Y_W] ? '1 : sum[Y_W-1:0];
  endfunction

  sample_set_t                  cur_v, prev_v;
  logic [CHANNELS-1:0]          cur_vld_v, prev_vld_v;
  logic [CHANNELS-1:0][Y_W-1:0] plot_cur, plot_prev;
  logic [CHANNELS-1:0]          hit;
  logic [23:0]                  color;

  // The boundary pixel already belongs to the new column, so it sees the
  // shifted view that the registers only take on at the end of this cycle.
  always_comb begin
    cur_v      = shift ? nxt_q : cur_q;
    prev_v     = shift ? cur_q : prev_q;
    cur_vld_v  = shift ? nxt_vld_q : cur_vld_q;
    prev_vld_v = shift ? (first_col ? '0 : cur_vld_q) : prev_vld_q;
  end

  // Per-channel hit and lowest-index colour selection.
  always_comb begin
    plot_cur  = '0;
    plot_prev = '0;
    hit       = '0;
    color     = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      plot_cur[i]  = plot_of(cur_v[i]);
      plot_prev[i] = plot_of(prev_v[i]);
      if (bus.ch_enable[i] && cur_vld_v[i]) begin
        if (bus.dot_mode || !prev_vld_v[i]) begin
          hit[i] = (y_val == plot_cur[i]);
        end else begin
          hit[i] = ((y_val >= plot_prev[i]) && (y_val <= plot_cur[i])) ||
                   ((y_val >= plot_cur[i])  && (y_val <= plot_prev[i]));
        end
      end
    end
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (hit[i]) begin
        color = CH_COLORS[24*i +: 24];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registered output
  // ---------------------------------------------------------------------------
  logic [23:0] rgb_q;
  logic        valid_pixel_q;

  // Register the pixel colour and the window flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb_q         <= '0;
      valid_pixel_q <= 1'b0;
    end else begin
      valid_pixel_q <= bus.valid && in_window;
      rgb_q         <= (bus.valid && in_window) ? color : 24'h000000;
    end
  end

  assign bus.r           = rgb_q[23:16];
  assign bus.g           = rgb_q[15:8];
  assign bus.b           = rgb_q[7:0];
  assign bus.valid_pixel = valid_pixel_q;

endmodule

// File: tb/tb_wave_display_mc.sv
// Directed bench for wave_display_mc: a 1-clk-latency RAM model, a table of
// single-pixel line/dot/priority vectors, and hand-written sequences for
// fetch order, reset and valid drop.
module tb_wave_display_mc;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  wave_display_mc_if #(.CHANNELS(4), .SAMPLE_W(8), .COL_BITS(7)) bus ();

  wave_display_mc dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Sample RAM: data appears one clk after the address.
  logic [7:0] mem [1024];
  always @(posedge clk) bus.read_value <= mem[bus.read_address];

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic int addr_of(input int idx, input int ch, input int col);
    return idx * 512 + ch * 128 + col;
  endfunction

  // Hold valid low for n cycles (inputs change #1 after posedge).
  task automatic blank(input int n);
    bus.valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // Ramp one line from x=244 with constant y; return the output for x=probe.
  task automatic run_line(input logic idx, input logic [3:0] en, input logic dm,
                          input int yv, input int probe,
                          output logic [23:0] rgb_got, output logic vp_got);
    bus.read_index = idx;
    bus.ch_enable  = en;
    bus.dot_mode   = dm;
    bus.y          = 10'(yv * 2);
    rgb_got        = 'x;
    vp_got         = 1'bx;
    for (int xi = 244; xi <= probe + 1; xi++) begin
      bus.x     = 11'(xi);
      bus.valid = 1'b1;
      @(negedge clk);
      if (xi == probe + 1) begin
        rgb_got = {bus.r, bus.g, bus.b};
        vp_got  = bus.valid_pixel;
      end
      @(posedge clk); #1;
    end
    blank(3);
  endtask

  typedef struct {
    logic        idx;
    logic [3:0]  en;
    logic        dm;
    int          yv;
    int          probe;
    logic [23:0] rgb;
    logic        vp;
  } vec_t;

  vec_t vecs[21];

  typedef struct {
    int x;
    int addr;
  } fetch_t;

  fetch_t fetches[10];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] rgb_got;
    logic        vp_got;

    // Buffer 1: ch0 = 64,128,64,64,...; ch1..3 = 255 everywhere.
    // Buffer 0: ch0 and ch1 = 64,128,0,...; ch2..3 = 255 everywhere.
    for (int a = 0; a < 1024; a++) mem[a] = 8'h00;
    for (int c = 0; c < 128; c++) begin
      mem[addr_of(1, 0, c)] = 8'd64;
      for (int ch = 1; ch < 4; ch++) mem[addr_of(1, ch, c)] = 8'd255;
      for (int ch = 2; ch < 4; ch++) mem[addr_of(0, ch, c)] = 8'd255;
    end
    mem[addr_of(1, 0, 1)] = 8'd128;
    mem[addr_of(0, 0, 0)] = 8'd64;
    mem[addr_of(0, 0, 1)] = 8'd128;
    mem[addr_of(0, 1, 0)] = 8'd64;
    mem[addr_of(0, 1, 1)] = 8'd128;

    //          idx   en     dm    yv   probe  rgb          vp
    vecs[0]  = '{1'b1, 4'hF, 1'b0,  64, 260, 24'hFFFF00, 1'b1};
    vecs[1]  = '{1'b1, 4'hF, 1'b0,  65, 260, 24'h000000, 1'b1};
    vecs[2]  = '{1'b1, 4'hF, 1'b0,  63, 256, 24'h000000, 1'b1};
    vecs[3]  = '{1'b1, 4'hF, 1'b0,  64, 256, 24'hFFFF00, 1'b1};
    vecs[4]  = '{1'b1, 4'hF, 1'b0,  64, 264, 24'hFFFF00, 1'b1};
    vecs[5]  = '{1'b1, 4'hF, 1'b0,  80, 268, 24'hFFFF00, 1'b1};
    vecs[6]  = '{1'b1, 4'hF, 1'b0,  96, 271, 24'hFFFF00, 1'b1};
    vecs[7]  = '{1'b1, 4'hF, 1'b0,  97, 266, 24'h000000, 1'b1};
    vecs[8]  = '{1'b1, 4'hF, 1'b1,  96, 266, 24'hFFFF00, 1'b1};
    vecs[9]  = '{1'b1, 4'hF, 1'b1,  80, 266, 24'h000000, 1'b1};
    vecs[10] = '{1'b1, 4'hF, 1'b1,  64, 260, 24'hFFFF00, 1'b1};
    vecs[11] = '{1'b1, 4'hF, 1'b0,  64, 255, 24'h000000, 1'b0};
    vecs[12] = '{1'b1, 4'hF, 1'b0, 159, 260, 24'h00FFFF, 1'b1};
    vecs[13] = '{1'b0, 4'hF, 1'b0,  64, 260, 24'hFFFF00, 1'b1};
    vecs[14] = '{1'b0, 4'hE, 1'b0,  64, 260, 24'h00FFFF, 1'b1};
    vecs[15] = '{1'b0, 4'h0, 1'b0,  64, 260, 24'h000000, 1'b1};
    vecs[16] = '{1'b0, 4'hE, 1'b0,  90, 266, 24'h00FFFF, 1'b1};
    vecs[17] = '{1'b0, 4'h4, 1'b0, 159, 260, 24'hFF00FF, 1'b1};
    vecs[18] = '{1'b0, 4'h8, 1'b0, 159, 260, 24'hFFFFFF, 1'b1};
    vecs[19] = '{1'b0, 4'hF, 1'b0, 159, 260, 24'hFF00FF, 1'b1};
    vecs[20] = '{1'b1, 4'hF, 1'b1,  64, 264, 24'h000000, 1'b1};

    fetches[0] = '{248, 'h200};
    fetches[1] = '{249, 'h280};
    fetches[2] = '{250, 'h300};
    fetches[3] = '{251, 'h380};
    fetches[4] = '{253, 'h380};
    fetches[5] = '{256, 'h201};
    fetches[6] = '{257, 'h281};
    fetches[7] = '{258, 'h301};
    fetches[8] = '{259, 'h381};
    fetches[9] = '{304, 'h207};

    // ---- Reset state ----
    reset          = 1'b1;
    bus.x          = '0;
    bus.y          = '0;
    bus.valid      = 1'b0;
    bus.read_index = 1'b0;
    bus.ch_enable  = 4'hF;
    bus.dot_mode   = 1'b0;
    #23;
    check("reset_rgb",  32'({bus.r, bus.g, bus.b}), 32'h0);
    check("reset_vp",   32'(bus.valid_pixel), 32'h0);
    check("reset_addr", 32'(bus.read_address), 32'h0);
    reset = 1'b0;
    @(posedge clk); #1;

    // ---- Fetch order and mid-line read_index flip ----
    bus.read_index = 1'b1;
    bus.y          = 10'd0;
    for (int xi = 240; xi <= 306; xi++) begin
      bus.x     = 11'(xi);
      bus.valid = 1'b1;
      if (xi == 300) bus.read_index = 1'b0;
      @(negedge clk);
      for (int f = 0; f < 10; f++) begin
        if (fetches[f].x == xi) begin
          check($sformatf("fetch_addr_x%0d", xi), 32'(bus.read_address), 32'(fetches[f].addr));
        end
      end
      @(posedge clk); #1;
    end
    blank(3);

    // ---- Table of single-pixel vectors ----
    foreach (vecs[i]) begin
      run_line(vecs[i].idx, vecs[i].en, vecs[i].dm, vecs[i].yv, vecs[i].probe, rgb_got, vp_got);
      check($sformatf("vec%0d_rgb", i), 32'(rgb_got), 32'(vecs[i].rgb));
      check($sformatf("vec%0d_vp",  i), 32'(vp_got),  32'(vecs[i].vp));
    end

    // ---- Reset mid-line, then no pre-roll: stays black ----
    bus.read_index = 1'b1;
    bus.ch_enable  = 4'hF;
    bus.dot_mode   = 1'b0;
    bus.y          = 10'd128;
    for (int xi = 244; xi <= 260; xi++) begin
      bus.x     = 11'(xi);
      bus.valid = 1'b1;
      @(posedge clk); #1;
    end
    #1;
    check("pre_reset_rgb", 32'({bus.r, bus.g, bus.b}), 32'hFFFF00);
    reset = 1'b1;
    #1;
    check("async_reset_rgb",  32'({bus.r, bus.g, bus.b}), 32'h0);
    check("async_reset_vp",   32'(bus.valid_pixel), 32'h0);
    check("async_reset_addr", 32'(bus.read_address), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    for (int xi = 262; xi <= 275; xi++) begin
      bus.x = 11'(xi);
      @(negedge clk);
      if (xi == 267) check("post_reset_black", 32'({bus.r, bus.g, bus.b}), 32'h0);
      @(posedge clk); #1;
    end
    blank(3);

    // ---- Valid drop mid-line ----
    bus.y = 10'd128;
    for (int xi = 244; xi <= 420; xi++) begin
      bus.x     = 11'(xi);
      bus.valid = !(xi >= 400 && xi <= 402);
      @(negedge clk);
      if (xi == 397) check("drop_before_rgb", 32'({bus.r, bus.g, bus.b}), 32'hFFFF00);
      if (xi == 401) check("drop_vp",         32'(bus.valid_pixel), 32'h0);
      if (xi == 408) check("drop_addr_held",  32'(bus.read_address), 32'h392);
      if (xi == 411) check("drop_after_rgb",  32'({bus.r, bus.g, bus.b}), 32'h0);
      @(posedge clk); #1;
    end
    blank(3);
    run_line(1'b1, 4'hF, 1'b0, 64, 290, rgb_got, vp_got);
    check("next_line_rgb", 32'(rgb_got), 32'hFFFF00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
